// File: rtl/pool_pkg.sv
// ---------------------------------------------------------------------------
// pool_pkg
// Shared sizing helpers for the 2x2 stride-2 max-pool stream.
//   cnt_width(n) : bits needed for a counter or index covering 0..n-1 (min 1)
//   out_dim(n)   : pooled dimension for an input dimension n (floored)
// The pooled dimensions and counter widths of max_pool_stream are derived
// from its INPUT_H / INPUT_W parameters through these functions.
// ---------------------------------------------------------------------------
package pool_pkg;

    localparam int POOL_K = 2;

    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    function automatic int out_dim(input int n);
        return n / POOL_K;
    endfunction

endpackage

// File: rtl/pool_max2.sv
// ---------------------------------------------------------------------------
// pool_max2
// Two-operand maximum of one channel element.
//   i_a, i_b : operands (DATA_WIDTH bits)
//   o_max    : the larger operand; equal operands return that value
// SIGNED_CMP = 1 compares as two's complement, 0 compares unsigned.
// ---------------------------------------------------------------------------
module pool_max2 #(
    parameter int DATA_WIDTH = 16,
    parameter int SIGNED_CMP = 1
) (
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic [DATA_WIDTH-1:0] o_max
);

    generate
        if (SIGNED_CMP != 0) begin : gen_signed
            assign o_max = ($signed(i_a) >= $signed(i_b)) ? i_a : i_b;
        end else begin : gen_unsigned
            assign o_max = (i_a >= i_b) ? i_a : i_b;
        end
    endgenerate

endmodule

// File: rtl/max_pool_stream.sv
// ---------------------------------------------------------------------------
// max_pool_stream
// 2x2 stride-2 max pooling over a raster-order pixel stream, DEPTH channels
// per pixel word (channel 0 in the MSBs), one cycle of latency.
//   clk, rst_n           : clock, asynchronous active-low reset
//   clear                : synchronous frame abort (counters, pair, output)
//   in_valid/in_ready    : input pixel handshake, in_data one pixel
//   out_valid/out_ready  : output pooled-pixel handshake, out_data
//   frame_done           : high on the handshake of the frame's last output
//
// Handshake: a word moves on a side only in a cycle where valid and ready
// are both high; a producer holds valid and data steady until that cycle.
// in_ready = (!out_valid || out_ready) && !clear, so an input that completes
// a window can always land in the output register.
//
// Data path: the even-column pixel of each pair sits in r_pair; on the odd
// column the horizontal max is formed. Even rows store it in the line buffer
// at col/2, odd rows combine it with that entry and load the output register.
// Odd trailing rows/columns are consumed but never reach the output.
// ---------------------------------------------------------------------------
module max_pool_stream
    import pool_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int INPUT_H    = 28,
    parameter int INPUT_W    = 28,
    parameter int DEPTH      = 1,
    parameter int SIGNED_CMP = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clear,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DEPTH*DATA_WIDTH-1:0] in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DEPTH*DATA_WIDTH-1:0] out_data,
    output logic                        frame_done
);

    localparam int DW    = DEPTH * DATA_WIDTH;
    localparam int OUT_H = out_dim(INPUT_H);
    localparam int OUT_W = out_dim(INPUT_W);
    localparam int CW_R  = cnt_width(INPUT_H);
    localparam int CW_C  = cnt_width(INPUT_W);
    localparam int LB_N  = OUT_W;
    localparam int LB_AW = cnt_width(LB_N);

    localparam logic [CW_R-1:0] ROW_LAST     = CW_R'(INPUT_H - 1);
    localparam logic [CW_C-1:0] COL_LAST     = CW_C'(INPUT_W - 1);
    localparam logic [CW_R-1:0] OUT_ROW_LAST = CW_R'(2 * OUT_H - 1);
    localparam logic [CW_C-1:0] OUT_COL_LAST = CW_C'(2 * OUT_W - 1);

    logic [CW_R-1:0]  r_row;
    logic [CW_C-1:0]  r_col;
    logic [DW-1:0]    r_pair;
    logic [DW-1:0]    r_lb [LB_N];
    logic [DW-1:0]    r_out_data;
    logic             r_out_valid;
    logic             r_out_last;

    logic             w_in_fire;
    logic             w_odd_row;
    logic             w_odd_col;
    logic             w_load;
    logic             w_lb_wr;
    logic [LB_AW-1:0] w_lb_idx;
    logic [DW-1:0]    w_lb_rd;
    logic [DW-1:0]    w_max_h;
    logic [DW-1:0]    w_max_v;

    assign in_ready   = (!r_out_valid || out_ready) && !clear;
    assign w_in_fire  = in_valid && in_ready;
    assign w_odd_row  = r_row[0];
    assign w_odd_col  = r_col[0];
    assign w_load     = w_in_fire && w_odd_row && w_odd_col;
    assign w_lb_wr    = w_in_fire && !w_odd_row && w_odd_col;
    assign w_lb_idx   = LB_AW'(r_col >> 1);
    // Only consulted on odd columns, where col/2 is always inside the buffer.
    assign w_lb_rd    = r_lb[w_lb_idx];

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    // The last-output tag rides with the output register; clear suppresses it.
    assign frame_done = r_out_valid && out_ready && r_out_last && !clear;

    // Two compare stages per channel: pair vs. pixel, then vs. line buffer.
    generate
        for (genvar ch = 0; ch < DEPTH; ch++) begin : gen_ch
            localparam int HI = DW - 1 - ch * DATA_WIDTH;

            pool_max2 #(
                .DATA_WIDTH (DATA_WIDTH),
                .SIGNED_CMP (SIGNED_CMP)
            ) u_max_h (
                .i_a   (r_pair[HI -: DATA_WIDTH]),
                .i_b   (in_data[HI -: DATA_WIDTH]),
                .o_max (w_max_h[HI -: DATA_WIDTH])
            );

            pool_max2 #(
                .DATA_WIDTH (DATA_WIDTH),
                .SIGNED_CMP (SIGNED_CMP)
            ) u_max_v (
                .i_a   (w_max_h[HI -: DATA_WIDTH]),
                .i_b   (w_lb_rd[HI -: DATA_WIDTH]),
                .o_max (w_max_v[HI -: DATA_WIDTH])
            );
        end
    endgenerate

    // Line buffer has no reset: every even row rewrites each entry before
    // the following odd row reads it.
    always_ff @(posedge clk) begin
        if (w_lb_wr) begin
            r_lb[w_lb_idx] <= w_max_h;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row       <= '0;
            r_col       <= '0;
            r_pair      <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (clear) begin
            r_row       <= '0;
            r_col       <= '0;
            r_pair      <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            if (w_in_fire) begin
                if (!w_odd_col) begin
                    r_pair <= in_data;
                end
                if (r_col == COL_LAST) begin
                    r_col <= '0;
                    r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
            // A load only happens when in_ready, i.e. the register is free
            // or being drained this cycle, so nothing pending is overwritten.
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_max_v;
                r_out_last  <= (r_row == OUT_ROW_LAST) && (r_col == OUT_COL_LAST);
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_max_pool_stream.sv
module tb_max_pool_stream;

    localparam int DW    = 16;
    localparam int PW    = 32;
    localparam int LIMIT = 2000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear_r     [3];
    logic          in_valid_r  [3];
    logic          out_ready_r [3];
    logic [PW-1:0] in_data_r   [3];
    logic          in_ready_w  [3];
    logic          out_valid_w [3];
    logic          frame_done_w[3];
    logic [PW-1:0] out_data_w  [3];

    int checks   = 0;
    int failures = 0;

    logic [PW-1:0] frame_q[$];
    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] got_q[$];
    bit            last_q[$];

    always #5 clk = ~clk;

    // u0: 4x4 signed, u1: 4x4 unsigned, u2: 5x5 signed; all two channels.
    max_pool_stream #(.DATA_WIDTH(DW), .INPUT_H(4), .INPUT_W(4), .DEPTH(2), .SIGNED_CMP(1)) u0 (
        .clk(clk), .rst_n(rst_n), .clear(clear_r[0]),
        .in_valid(in_valid_r[0]), .in_ready(in_ready_w[0]), .in_data(in_data_r[0]),
        .out_valid(out_valid_w[0]), .out_ready(out_ready_r[0]), .out_data(out_data_w[0]),
        .frame_done(frame_done_w[0])
    );

    max_pool_stream #(.DATA_WIDTH(DW), .INPUT_H(4), .INPUT_W(4), .DEPTH(2), .SIGNED_CMP(0)) u1 (
        .clk(clk), .rst_n(rst_n), .clear(clear_r[1]),
        .in_valid(in_valid_r[1]), .in_ready(in_ready_w[1]), .in_data(in_data_r[1]),
        .out_valid(out_valid_w[1]), .out_ready(out_ready_r[1]), .out_data(out_data_w[1]),
        .frame_done(frame_done_w[1])
    );

    max_pool_stream #(.DATA_WIDTH(DW), .INPUT_H(5), .INPUT_W(5), .DEPTH(2), .SIGNED_CMP(1)) u2 (
        .clk(clk), .rst_n(rst_n), .clear(clear_r[2]),
        .in_valid(in_valid_r[2]), .in_ready(in_ready_w[2]), .in_data(in_data_r[2]),
        .out_valid(out_valid_w[2]), .out_ready(out_ready_r[2]), .out_data(out_data_w[2]),
        .frame_done(frame_done_w[2])
    );

    task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [DW-1:0] ch_max(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input bit sgn);
        if (sgn) return ($signed(a) > $signed(b)) ? a : b;
        return (a > b) ? a : b;
    endfunction

    // Reference: every 2x2 window of the stored frame, per channel, floored dims.
    task automatic build_exp(input int h, input int w, input bit sgn);
        logic [PW-1:0] p;
        logic [PW-1:0] word;
        logic [DW-1:0] v;
        logic [DW-1:0] m;
        exp_q.delete();
        last_q.delete();
        for (int r = 0; r < h / 2; r++) begin
            for (int c = 0; c < w / 2; c++) begin
                word = '0;
                for (int ch = 0; ch < 2; ch++) begin
                    m = '0;
                    for (int k = 0; k < 4; k++) begin
                        p = frame_q[(2 * r + k / 2) * w + 2 * c + k % 2];
                        v = p[(1 - ch) * DW +: DW];
                        m = (k == 0) ? v : ch_max(m, v, sgn);
                    end
                    word[(1 - ch) * DW +: DW] = m;
                end
                exp_q.push_back(word);
                last_q.push_back((r == h / 2 - 1) && (c == w / 2 - 1));
            end
        end
    endtask

    task automatic fill_ramp(input int h, input int w);
        frame_q.delete();
        for (int i = 0; i < h * w; i++) begin
            frame_q.push_back({DW'(i), DW'(h * w - 1 - i)});
        end
    endtask

    task automatic fill_random(input int h, input int w);
        frame_q.delete();
        for (int i = 0; i < h * w; i++) frame_q.push_back($urandom());
    endtask

    // mode 0: always ready; 1: random valid/ready gaps; 2: 5-cycle stall on first output.
    task automatic run_frame(input int sel, input int h, input int w, input bit sgn, input int mode);
        int            idx;
        int            cyc;
        int            stall_left;
        int            n_out;
        bit            ov;
        bit            ordy;
        bit            iv;
        bit            prev_hold;
        bit            el;
        logic [PW-1:0] prev_data;
        logic [PW-1:0] e;
        build_exp(h, w, sgn);
        got_q.delete();
        idx        = 0;
        cyc        = 0;
        n_out      = 0;
        prev_hold  = 1'b0;
        prev_data  = '0;
        stall_left = (mode == 2) ? 5 : 0;
        while ((idx < h * w || exp_q.size() > 0) && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
            ov = out_valid_w[sel];
            if (mode == 2 && ov && stall_left > 0) begin
                ordy = 1'b0;
                stall_left--;
            end else if (mode == 1) begin
                ordy = ($urandom_range(0, 3) != 0);
            end else begin
                ordy = 1'b1;
            end
            iv = (idx < h * w) && ((mode != 1) || ($urandom_range(0, 4) != 0));
            in_valid_r[sel]  = iv;
            in_data_r[sel]   = iv ? frame_q[idx] : $urandom();
            out_ready_r[sel] = ordy;
            #1;
            chk("in_ready", in_ready_w[sel], !ov || ordy);
            if (prev_hold) begin
                chk("hold_valid", out_valid_w[sel], 1);
                chk("hold_data", out_data_w[sel], prev_data);
            end
            if (ov && ordy) begin
                chk("output_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e  = exp_q.pop_front();
                    el = last_q.pop_front();
                    chk("out_data", out_data_w[sel], e);
                    chk("frame_done", frame_done_w[sel], el);
                    got_q.push_back(out_data_w[sel]);
                    n_out++;
                end
            end else begin
                chk("frame_done_idle", frame_done_w[sel], 0);
            end
            prev_hold = ov && !ordy;
            prev_data = out_data_w[sel];
            if (iv && in_ready_w[sel]) idx++;
        end
        chk("timeout", cyc < LIMIT, 1);
        @(negedge clk);
        in_valid_r[sel]  = 1'b0;
        out_ready_r[sel] = 1'b0;
        #1;
        chk("out_count", n_out, (h / 2) * (w / 2));
        chk("idle_after_frame", out_valid_w[sel], 0);
    endtask

    task automatic chk_got_ch0(input string tag, input int k, input logic [DW-1:0] v);
        logic [PW-1:0] p;
        p = got_q[k];
        chk(tag, p[PW-1 -: DW], v);
    endtask

    task automatic chk_got_ch1(input string tag, input int k, input logic [DW-1:0] v);
        logic [PW-1:0] p;
        p = got_q[k];
        chk(tag, p[DW-1:0], v);
    endtask

    // Six pixels of a 4x4 frame with no downstream: window (0,0) is left pending.
    task automatic feed_partial(input int sel);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            in_valid_r[sel]  = 1'b1;
            in_data_r[sel]   = $urandom();
            out_ready_r[sel] = 1'b0;
            #1;
            chk("partial_in_ready", in_ready_w[sel], 1);
        end
        @(negedge clk);
        in_valid_r[sel] = 1'b0;
        #1;
        chk("partial_pending", out_valid_w[sel], 1);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int s = 0; s < 3; s++) begin
            clear_r[s]     = 1'b0;
            in_valid_r[s]  = 1'b0;
            out_ready_r[s] = 1'b0;
            in_data_r[s]   = '0;
        end
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            chk("reset_out_valid", out_valid_w[s], 0);
            chk("reset_frame_done", frame_done_w[s], 0);
            chk("reset_out_data", out_data_w[s], 0);
            chk("reset_in_ready", in_ready_w[s], 1);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // 4x4 ramp: ch0 0..15 up, ch1 15..0 down.
        fill_ramp(4, 4);
        run_frame(0, 4, 4, 1'b1, 0);
        chk_got_ch0("ramp_ch0_0", 0, 16'd5);
        chk_got_ch0("ramp_ch0_1", 1, 16'd7);
        chk_got_ch0("ramp_ch0_2", 2, 16'd13);
        chk_got_ch0("ramp_ch0_3", 3, 16'd15);
        chk_got_ch1("ramp_ch1_0", 0, 16'd15);
        chk_got_ch1("ramp_ch1_3", 3, 16'd5);

        // 5x5 ramp: last row and column dropped, then a second frame after the wrap.
        fill_ramp(5, 5);
        run_frame(2, 5, 5, 1'b1, 0);
        chk_got_ch0("odd_ch0_0", 0, 16'd6);
        chk_got_ch0("odd_ch0_1", 1, 16'd8);
        chk_got_ch0("odd_ch0_2", 2, 16'd16);
        chk_got_ch0("odd_ch0_3", 3, 16'd18);
        fill_random(5, 5);
        run_frame(2, 5, 5, 1'b1, 1);

        // Negative windows, same bits into the signed and unsigned instances.
        fill_random(4, 4);
        frame_q[0] = {16'hFFFD, frame_q[0][DW-1:0]};
        frame_q[1] = {16'h0005, frame_q[1][DW-1:0]};
        frame_q[4] = {16'hFFF8, frame_q[4][DW-1:0]};
        frame_q[5] = {16'hFFFE, frame_q[5][DW-1:0]};
        frame_q[2] = {16'hFFFD, frame_q[2][DW-1:0]};
        frame_q[3] = {16'hFFFF, frame_q[3][DW-1:0]};
        frame_q[6] = {16'hFFF8, frame_q[6][DW-1:0]};
        frame_q[7] = {16'hFFFE, frame_q[7][DW-1:0]};
        run_frame(0, 4, 4, 1'b1, 0);
        chk_got_ch0("signed_mixed", 0, 16'h0005);
        chk_got_ch0("signed_neg", 1, 16'hFFFF);
        run_frame(1, 4, 4, 1'b0, 0);
        chk_got_ch0("unsigned_mixed", 0, 16'hFFFE);
        chk_got_ch0("unsigned_neg", 1, 16'hFFFF);

        // Backpressure: a held output, then random gaps.
        fill_random(4, 4);
        run_frame(0, 4, 4, 1'b1, 2);
        fill_random(4, 4);
        run_frame(1, 4, 4, 1'b0, 1);

        // Abort a frame with clear, then a full frame.
        feed_partial(0);
        @(negedge clk);
        clear_r[0] = 1'b1;
        #1;
        chk("clear_in_ready", in_ready_w[0], 0);
        chk("clear_frame_done", frame_done_w[0], 0);
        @(negedge clk);
        clear_r[0] = 1'b0;
        #1;
        chk("clear_out_valid", out_valid_w[0], 0);
        fill_random(4, 4);
        run_frame(0, 4, 4, 1'b1, 0);

        // Abort a frame with a reset pulse, then a full frame.
        feed_partial(1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid_w[1], 0);
        chk("rst_out_data", out_data_w[1], 0);
        @(negedge clk);
        rst_n = 1'b1;
        fill_random(4, 4);
        run_frame(1, 4, 4, 1'b0, 0);

        // Random frames with random handshakes on every instance.
        for (int f = 0; f < 3; f++) begin
            for (int s = 0; s < 3; s++) begin
                fill_random((s == 2) ? 5 : 4, (s == 2) ? 5 : 4);
                run_frame(s, (s == 2) ? 5 : 4, (s == 2) ? 5 : 4, s != 1, 1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/max_pool_stream.md
MAX_POOL_STREAM -- requirements
Module: max_pool_stream

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, width of one channel element.
REQ-002 The block SHALL have parameter INPUT_H, default 28, feature-map rows per frame (>=2).
REQ-003 The block SHALL have parameter INPUT_W, default 28, feature-map columns per frame (>=2).
REQ-004 The block SHALL have parameter DEPTH, default 1, channels carried in parallel per pixel word.
REQ-005 The block SHALL have parameter SIGNED_CMP, default 1, 1 = two's-complement compare, 0 = unsigned compare.
REQ-006 The block SHALL have one clock and an asynchronous, active-low reset; ports SHALL be listed clock first, then reset.
REQ-007 clk  input  1  rising-edge clock.
REQ-008 rst_n  input  1  asynchronous active-low reset.
REQ-009 clear  input  1  synchronous frame abort; drops partial state.
REQ-010 in_valid  input  1  in_data holds a pixel.
REQ-011 in_ready  output  1  block accepts the pixel this cycle.
REQ-012 in_data  input  DEPTH*DATA_WIDTH  one pixel, channel 0 in the MSBs.
REQ-013 out_valid  output  1  out_data holds a pooled pixel.
REQ-014 out_ready  input  1  downstream accepts out_data.
REQ-015 out_data  output  DEPTH*DATA_WIDTH  pooled pixel, same channel packing as in_data.
REQ-016 frame_done  output  1  one-cycle pulse on the handshake of a frame's last pooled pixel.

Function
REQ-017 The block SHALL perform 2x2 stride-2 max pooling per channel on pixels arriving in raster order (row-major, column fastest).
REQ-018 Output dimensions SHALL be INPUT_H/2 x INPUT_W/2, floored; an odd last row or column SHALL be accepted and discarded.
REQ-019 A transfer SHALL occur only on a cycle with valid and ready both high, on each side.
REQ-020 in_ready SHALL equal (!out_valid || out_ready) && !clear.
REQ-021 Column and row counters SHALL advance on each input transfer and wrap to 0,0 after pixel (INPUT_H-1, INPUT_W-1).
REQ-022 Even row, even column: the pixel SHALL be held in a pair register.
REQ-023 Even row, odd column: the per-channel max of the pair register and the pixel SHALL be written to line-buffer entry col/2 (INPUT_W/2 entries x DEPTH*DATA_WIDTH).
REQ-024 Odd row, even column: the pixel SHALL be held in the pair register.
REQ-025 Odd row, odd column: the per-channel max of the pair register, the pixel and line-buffer entry col/2 SHALL load the output register, and out_valid SHALL be set.
REQ-026 Latency SHALL be one cycle: out_valid rises on the cycle after the bottom-right window pixel transfers.
REQ-027 out_valid and out_data SHALL stay stable while out_valid && !out_ready.
REQ-028 A new output load and an output handshake in the same cycle SHALL keep out_valid high with the new data.
REQ-029 Equal operands SHALL give that value; the compare SHALL follow SIGNED_CMP.
REQ-030 Results SHALL be exact, with no rounding or saturation; output width SHALL equal input width.
REQ-031 clear SHALL zero the counters and pair register and drop out_valid in the same edge, with no frame_done pulse.
REQ-032 Line-buffer contents SHALL need no clear, because even rows overwrite every entry before it is read.
REQ-033 frame_done SHALL pulse when the output handshake carries pooled pixel (INPUT_H/2-1, INPUT_W/2-1).

Reset
REQ-034 On rst_n low the block SHALL set out_valid=0, frame_done=0, out_data=0, counters=0, pair register=0; in_ready SHALL then follow REQ-020.
REQ-035 Reset asserted mid-frame SHALL abandon the frame; the first pixel after release SHALL be treated as pixel (0,0).

Structure
REQ-036 A shared package pool_pkg SHALL hold the output-dimension and counter-width constants (clog2 of INPUT_W and INPUT_H).
REQ-037 Per-channel compare SHALL be a sub-module pool_max2 (two operands, SIGNED_CMP parameter), instantiated per channel for each compare stage.

Verification
REQ-038 4x4 frame, DEPTH=1, values 0..15 raster, out_ready=1 -> outputs 5,7,13,15; frame_done on the 4th output.
REQ-039 SIGNED_CMP=1, window {-3,-1,-8,-2} -> -1; same bits with SIGNED_CMP=0 -> 0xFFFF (-1 as unsigned is largest).
REQ-040 5x5 frame, values 0..24 -> outputs 6,8,16,18; row 4 and column 4 dropped; counters wrap for the next frame.
REQ-041 DEPTH=2, ch0 ramps up and ch1 ramps down on a 4x4 frame -> each channel is pooled independently in its own out_data slice.
REQ-042 out_ready held low 5 cycles with an output pending -> in_ready=0 and out_data stable; no loss or duplication after release.
REQ-043 clear asserted after 6 pixels, then a full 4x4 frame -> exactly 4 correct outputs, one frame_done; rst_n pulse mid-frame gives the same result.
